// File: rtl/uartin_if.sv
// Bundle between the serial receiver and its surroundings: the serial pin,
// the FIFO full flag, and the FIFO write side (byte, strobe, error pulses).
// master: the receiver (reads rx/n_full, drives data/n_wr/frame_err/overrun).
// slave:  the pin/FIFO side (drives rx/n_full, reads the receiver outputs).
interface uartin_if;
  logic       rx;
  logic       n_full;
  logic [7:0] data;
  logic       n_wr;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  rx,
    input  n_full,
    output data,
    output n_wr,
    output frame_err,
    output overrun
  );

  modport slave (
    output rx,
    output n_full,
    input  data,
    input  n_wr,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uartin.sv
// 8N1 serial receiver feeding a FIFO write port via an active-low strobe.
// Latency: write/flag pulse appears after the mid-stop-bit sample, about 2 + CDIV/2 + 9*CDIV cycles after the start edge.
// Backpressure: n_full is looked at only at the stop sample; a full FIFO drops the byte and pulses overrun.
// Ports: clk, rst (async, active-high), bus (uartin_if.master):
//   bus.rx in, bus.n_full in, bus.data[7:0] out, bus.n_wr out, bus.frame_err out, bus.overrun out.
module uartin #(
  parameter int CDIV = 434
) (
  input  logic      clk,
  input  logic      rst,
  uartin_if.master  bus
);

  localparam int            CW      = $clog2(CDIV + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_H   = CW'(CDIV / 2);
  localparam logic [CW-1:0] CNT_BIT = CW'(CDIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          n_wr_q, n_wr_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          rx_meta_q, rx_s_q;

  // Two-flop synchronizer; resets to the idle (HIGH) line level so that
  // reset release never looks like a start edge by itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= 8'h00;
      n_wr_q      <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      n_wr_q      <= n_wr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // cnt reads N on the N-th edge spent in a state: it is loaded with 1 on
  // entry and on every sample edge, and counts up otherwise. In IDLE and
  // BREAK it is unused and simply held.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    n_wr_d      = 1'b1;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = CNT_ONE;
        end
      end

      // Mid-start-bit check; a line back HIGH here was only a glitch.
      S_START: begin
        if (cnt_q == CNT_H) begin
          cnt_d = CNT_ONE;
          if (!rx_s_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d          = CNT_ONE;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Returning to IDLE at mid-stop-bit leaves half a bit to catch a
      // start edge that immediately follows.
      S_STOP: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d = CNT_ONE;
          if (rx_s_q) begin
            state_d = S_IDLE;
            if (bus.n_full) begin
              data_d = shift_q;
              n_wr_d = 1'b0;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A line held LOW after a bad stop bit must go HIGH before the next
      // start bit is accepted, otherwise a break decodes as 0x00 frames.
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ONE;
      end
    endcase
  end

  assign bus.data      = data_q;
  assign bus.n_wr      = n_wr_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: doc/uartin.md
# uartin

Serial receiver for the character-generator FIFO path. It recovers 8N1 asynchronous frames from the `rx` pin: one start bit (LOW), eight data bits LSB first, and one stop bit (HIGH), with an idle level of HIGH. Each received byte is pushed into the downstream FIFO through an active-low write strobe, gated by the FIFO's active-low full flag. The block sits between the board's serial input pin and the FIFO write port.

## Interface
Parameters:
- `CDIV`, default 434: clock cycles per bit. Legal range is ≥ 4.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `rx`  in  1  serial input, asynchronous to `clk`, idle HIGH.
- `n_full`  in  1  FIFO full flag, active-low; LOW means the FIFO cannot accept a write.
- `data`  out  8  received byte, valid while `n_wr` is LOW.
- `n_wr`  out  1  FIFO write strobe, active-low, one cycle wide.
- `frame_err`  out  1  one-cycle HIGH pulse when the stop bit is sampled LOW.
- `overrun`  out  1  one-cycle HIGH pulse when a good byte is dropped because `n_full` is LOW.

## Operation
Input synchronizer:
- `rx` passes through a 2-flop synchronizer to produce `rx_s`.
- Both flops reset to 1.
- The FSM uses only `rx_s`.

Bit counter:
- `cnt` is sized to `$clog2(CDIV+1)` bits.
- It is loaded with 1 on the edge that enters a state.
- It increments on every later edge while the FSM stays in that state.
- "Sample at N" means the action occurs on the edge where `cnt == N`; that edge also reloads `cnt` to 1.
- Let H = CDIV/2, using integer division.

FSM states:
- IDLE: when `rx_s` == 0, go to START.
- START: sample at H.
  - `rx_s` == 0: go to DATA with `idx` = 0.
  - `rx_s` == 1: treat as a glitch and return to IDLE. No flags are raised.
- DATA: sample at CDIV.
  - Store `shift[idx]` = `rx_s`, then `idx` = `idx` + 1.
  - After the sample with `idx` == 7, go to STOP.
- STOP: sample at CDIV.
  - `rx_s` == 1 and `n_full` == 1: register `data` = `shift` and `n_wr` = 0. Go to IDLE.
  - `rx_s` == 1 and `n_full` == 0: `overrun` = 1, no write. Go to IDLE.
  - `rx_s` == 0: `frame_err` = 1, no write. Go to BREAK.
- BREAK: wait for `rx_s` == 1, then go to IDLE. This prevents a held-LOW line (break) from being decoded as repeated 0x00 frames.

Output behaviour:
- `n_wr`, `frame_err` and `overrun` are registered.
- Each returns to its inactive level on the edge after it was asserted.
- `data` holds its last value until the next good byte.
- `n_full` is sampled only at the stop-bit edge. It is ignored at all other times.

Reset values:
- FSM state: IDLE.
- `n_wr`: 1.
- `frame_err`: 0.
- `overrun`: 0.
- `data`: 8'h00.
- `cnt`: 0.
- `idx`: 0.
- Synchronizer flops: 1.

Reset mid-frame:
- The partial byte is discarded.
- No strobe or flag is produced.
- After reset releases, the receiver resumes in IDLE. A line that is still LOW is treated as a new start bit.

## Timing
Let E0 be the edge on which the FSM leaves IDLE. E0 is 2 edges after the edge at which the first synchronizer flop captures the falling `rx`.

- Start check: E0 + H.
- Data bit k (k = 0..7): sampled at E0 + H + (k+1)·CDIV.
- Stop bit: sampled at E0 + H + 9·CDIV. `n_wr`, `overrun` or `frame_err` becomes valid immediately after this edge and lasts one cycle.
- Back-to-back frames: the FSM is in IDLE half a bit before the nominal end of the stop bit. A start edge that immediately follows a stop bit is therefore caught with no lost frames.
- Sampling tolerance is about ±H/(9.5·CDIV) of bit-rate mismatch (about ±5%).
- Throughput: at most one write per 9.5·CDIV + 2 cycles.

## Test plan
All scenarios use `CDIV` = 8, so H = 4, and drive `rx` with 8-cycle bits.

1. Reset: assert `rst` while `rx` = 1, then release. Required: `n_wr` = 1, `frame_err` = 0, `overrun` = 0, `data` = 8'h00, and no strobe for 200 cycles of idle.
2. Single byte 8'h53 ("S"), sent LSB first. Required: exactly one `n_wr` LOW pulse, 1 cycle wide, with `data` = 8'h53, at E0 + 76 (4 + 9·8).
3. Back-to-back bytes 8'h53 then 8'h74 ("t"), with no idle gap. Required: two strobes, carrying 8'h53 and then 8'h74, spaced exactly 80 cycles apart. No flags.
4. Glitch and frame error:
   - A 2-cycle LOW glitch on an idle line. Required: no strobe and no flag.
   - A frame for 8'hA5 whose stop bit is driven LOW, then the line is held LOW for 30 cycles. Required: one `frame_err` pulse at E0 + 76 and no `n_wr`. A following valid 8'h3C is received only after the line returns HIGH.
5. Overrun: hold `n_full` = 0 while sending 8'h41. Required: one `overrun` pulse at the stop sample and `n_wr` stays 1. Then release `n_full` and send 8'h42. Required: the write carries 8'h42.
6. Reset mid-frame: assert `rst` at E0 + 40 during 8'hFF. Required: no strobe and no flag. After release and a full idle bit, 8'h55 is received correctly.
